line_loader: RTL and testbench
==============================

LINE_LOADER -- requirements
Module: line_loader

Interface
REQ-001 The block SHALL have these ports: reset rst, synchronous, active-high; clock clk.
REQ-002 Remaining ports SHALL be:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- enable  in  1  permits IDLE->LHS
- in_valid  in  1  byte offered
- in_data  in  8  ASCII byte, alternating lhs then rhs
- in_last  in  1  byte closes current line
- in_ready  out  1  byte accepted when in_valid&in_ready
- mem_we  out  1  char-pair write strobe
- mem_addr  out  10  char-pair word address
- mem_din  out  16  {lhs[15:8], rhs[7:0]}
- ptr_we  out  1  pointer-table write strobe
- ptr_idx  out  8  line index being written
- ptr_data  out  20  {len[19:10], start[9:0]}
- lines_written  out  8  committed line count, saturating at 255
- overflow  out  1  sticky capacity error
- which_state  out  4  state code for debug

Function
REQ-003 States and which_state codes SHALL be: IDLE=0, LHS=1, RHS=2, WRITE=3, COMMIT=4, FULL=5.
REQ-004 IDLE SHALL move to LHS on the first cycle with enable=1; in_ready=0 in IDLE.
REQ-005 in_ready SHALL be 1 only in LHS and RHS; it SHALL be 0 in WRITE, COMMIT, FULL and IDLE.
REQ-006 In LHS, an accepted byte SHALL be latched as lhs:
- in_last=0 -> RHS
- in_last=1 -> WRITE, with rhs=lhs (identity pad) and line-close pending
REQ-007 In RHS, an accepted byte SHALL be latched as rhs, with line-close pending set to in_last, then state -> WRITE.
REQ-008 WRITE SHALL last exactly one cycle with:
- mem_we=1, mem_din={lhs,rhs}, mem_addr=wr_addr
- next cycle: wr_addr+1, line_len+1
- next state COMMIT if close pending, else LHS
REQ-009 mem_we SHALL rise on the cycle after the rhs byte is accepted (latency 1).
REQ-010 COMMIT SHALL last exactly one cycle with:
- ptr_we=1, ptr_idx=lines_written
- ptr_data={line_len, line_start}, where line_len counts the words of this line, including the word just written
REQ-011 After COMMIT, the block SHALL:
- set line_start to the current wr_addr
- clear line_len
- increment lines_written
- go to LHS
REQ-012 Every line SHALL contain at least one word; a zero-length line is never committed.
REQ-013 Address 10'h3FF SHALL be reserved (read-side idle address) and SHALL never be written.
- If wr_addr would advance to 10'h3FF after a WRITE, the block SHALL set overflow=1 and go to FULL.
- If close was pending, COMMIT of that line SHALL still occur first, then FULL.
REQ-014 After COMMIT of line index 255, the block SHALL go to FULL with overflow=0; lines_written SHALL read 255.
REQ-015 FULL SHALL be terminal until rst: no mem_we, no ptr_we, in_ready=0.
REQ-016 mem_we and ptr_we SHALL never be high in the same cycle.
REQ-017 All arithmetic SHALL be unsigned 10-bit for addresses and lengths, with no wrap past 10'h3FE.
REQ-018 in_data/in_last SHALL be ignored whenever in_valid&in_ready=0.
REQ-019 mem_addr SHALL continuously show wr_addr, and mem_din the last latched pair, outside WRITE.

Reset
REQ-020 On rst=1 at a clock edge, the block SHALL apply these reset values:
- state=IDLE, which_state=0
- wr_addr=mem_addr=0, line_start=0, line_len=0
- lines_written=0, overflow=0
- in_ready=0, mem_we=0, ptr_we=0, ptr_idx=0, ptr_data=0, mem_din=0
REQ-021 Reset SHALL take priority over every other input, including mid-line and in FULL; a partially received line SHALL be discarded without ptr_we.

Verification
REQ-022 Bench SHALL cover these directed scenarios:
- Basic: rst, enable=1, send "a","A","b","B"(last). Required: mem writes addr0=16'h6141 and addr1=16'h6242, then ptr_we with idx0 and ptr_data={10'd2,10'd0}; lines_written=1.
- Second line start: continuing from the basic case, send "c","C"(last). Required: mem addr2=16'h6343, then ptr_data={10'd1,10'd2} at idx1.
- Odd pad: send "x"(last) on the lhs slot. Required: mem_din=16'h7878, ptr len=1.
- Backpressure: hold in_valid=1 continuously. Required: in_ready=0 in WRITE and COMMIT, and no byte is lost or duplicated (count accepted bytes = 2*words).
- Capacity: stream 1023 words in a single line, closing on the last. Required: the last write goes to 10'h3FE, ptr_data={10'd1023,10'd0}, then FULL with overflow=1 and no write to 10'h3FF.
- Reset mid-line: rst after the lhs byte is accepted. Required: no ptr_we, all outputs at reset values, and the next line starts at addr0.

Source files
------------

// File: rtl/line_loader.sv
// Packs an ASCII byte stream into 16-bit char-pair words and records a {len,start} pointer for each closed line.
// Latency: a word is written the cycle after its rhs byte is accepted; the pointer is written on the next cycle.
// Backpressure: in_ready drops during WRITE/COMMIT, in IDLE, and permanently once FULL.
module line_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        mem_we,
    output logic [9:0]  mem_addr,
    output logic [15:0] mem_din,
    output logic        ptr_we,
    output logic [7:0]  ptr_idx,
    output logic [19:0] ptr_data,
    output logic [7:0]  lines_written,
    output logic        overflow,
    output logic [3:0]  which_state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LHS    = 4'd1,
        S_RHS    = 4'd2,
        S_WRITE  = 4'd3,
        S_COMMIT = 4'd4,
        S_FULL   = 4'd5
    } state_t;

    // 10'h3FF is the read side's idle address, so the last writable word is 10'h3FE.
    localparam logic [9:0] LAST_ADDR = 10'h3FE;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_lhs;
    logic [7:0]  r_rhs;
    logic        r_close;
    logic [9:0]  r_wr_addr;
    logic [9:0]  r_line_start;
    logic [9:0]  r_line_len;
    logic [7:0]  r_lines;
    logic        r_overflow;
    logic        w_accept;
    logic        w_at_last_addr;
    logic        w_lines_max;

    assign w_accept       = in_valid & in_ready;
    assign w_at_last_addr = (r_wr_addr == LAST_ADDR);
    assign w_lines_max    = (r_lines == 8'd255);

    assign mem_addr      = r_wr_addr;
    assign mem_din       = {r_lhs, r_rhs};
    assign ptr_idx       = r_lines;
    assign ptr_data      = {r_line_len, r_line_start};
    assign lines_written = r_lines;
    assign overflow      = r_overflow;
    assign which_state   = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        mem_we   = 1'b0;
        ptr_we   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_next = S_LHS;
                end
            end
            S_LHS: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    w_next = in_last ? S_WRITE : S_RHS;
                end
            end
            S_RHS: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_we = 1'b1;
                // A closing word still gets its pointer before the block stops.
                if (r_close) begin
                    w_next = S_COMMIT;
                end else if (w_at_last_addr) begin
                    w_next = S_FULL;
                end else begin
                    w_next = S_LHS;
                end
            end
            S_COMMIT: begin
                ptr_we = 1'b1;
                w_next = (r_overflow || w_lines_max) ? S_FULL : S_LHS;
            end
            S_FULL: begin
                w_next = S_FULL;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lhs        <= 8'd0;
            r_rhs        <= 8'd0;
            r_close      <= 1'b0;
            r_wr_addr    <= 10'd0;
            r_line_start <= 10'd0;
            r_line_len   <= 10'd0;
            r_lines      <= 8'd0;
            r_overflow   <= 1'b0;
        end else begin
            case (r_state)
                S_LHS: begin
                    if (w_accept) begin
                        r_lhs <= in_data;
                        if (in_last) begin
                            r_rhs   <= in_data;
                            r_close <= 1'b1;
                        end else begin
                            r_close <= 1'b0;
                        end
                    end
                end
                S_RHS: begin
                    if (w_accept) begin
                        r_rhs   <= in_data;
                        r_close <= in_last;
                    end
                end
                S_WRITE: begin
                    r_line_len <= r_line_len + 10'd1;
                    // Hold the address at the last legal word rather than stepping onto the reserved one.
                    if (w_at_last_addr) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_wr_addr <= r_wr_addr + 10'd1;
                    end
                end
                S_COMMIT: begin
                    r_line_start <= r_wr_addr;
                    r_line_len   <= 10'd0;
                    r_close      <= 1'b0;
                    if (!w_lines_max) begin
                        r_lines <= r_lines + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_loader.sv
// Self-checking bench for line_loader: directed scenarios plus randomized lines against a line-level model.
module tb_line_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [15:0] mem_din;
    logic        ptr_we;
    logic [7:0]  ptr_idx;
    logic [19:0] ptr_data;
    logic [7:0]  lines_written;
    logic        overflow;
    logic [3:0]  which_state;

    line_loader dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_din       (mem_din),
        .ptr_we        (ptr_we),
        .ptr_idx       (ptr_idx),
        .ptr_data      (ptr_data),
        .lines_written (lines_written),
        .overflow      (overflow),
        .which_state   (which_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Observed traffic, collected mid-cycle when inputs and state are both settled.
    logic [25:0] mem_q[$];
    logic [27:0] ptr_q[$];
    int          lat_q[$];
    int          cyc = 0;
    int          last_acc = 0;
    int          acc_cnt = 0;
    int          both_cnt = 0;
    int          bad_addr = 0;
    int          rdy_viol = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (in_valid && in_ready) begin
            acc_cnt  = acc_cnt + 1;
            last_acc = cyc;
        end
        if (mem_we) begin
            mem_q.push_back({mem_addr, mem_din});
            lat_q.push_back(cyc - last_acc);
            if (mem_addr == 10'h3FF) bad_addr = bad_addr + 1;
        end
        if (ptr_we) ptr_q.push_back({ptr_idx, ptr_data});
        if (mem_we && ptr_we) both_cnt = both_cnt + 1;
        if (in_ready && (mem_we || ptr_we)) rdy_viol = rdy_viol + 1;
    end

    // Line-level model: a line of n bytes becomes ceil(n/2) consecutive words, odd tail padded with itself.
    logic [7:0]  line_q[$];
    logic [25:0] exp_mem[$];
    logic [27:0] exp_ptr[$];
    int          m_addr;
    int          m_idx;
    bit          m_ovf;
    bit          m_full;
    int          exp_bytes;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        mem_q.delete(); ptr_q.delete(); lat_q.delete();
        exp_mem.delete(); exp_ptr.delete();
        acc_cnt = 0; both_cnt = 0; bad_addr = 0; rdy_viol = 0;
        m_addr = 0; m_idx = 0; m_ovf = 0; m_full = 0; exp_bytes = 0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        enable   = 1'b0;
        rst      = 1'b1;
        tick();
        tick();
        rst    = 1'b0;
        enable = 1'b1;
        clear_all();
    endtask

    task automatic model_line();
        int         nw;
        logic [9:0] start;
        logic [7:0] r;
        nw    = (line_q.size() + 1) / 2;
        start = m_addr[9:0];
        if (m_full) return;
        exp_bytes = exp_bytes + line_q.size();
        for (int k = 0; k < nw; k++) begin
            r = (2 * k + 1 < line_q.size()) ? line_q[2 * k + 1] : line_q[2 * k];
            exp_mem.push_back({m_addr[9:0], line_q[2 * k], r});
            m_addr = m_addr + 1;
            if (m_addr == 1023) begin
                m_ovf = 1;
                if (k != nw - 1) begin
                    m_full = 1;
                    return;
                end
            end
        end
        exp_ptr.push_back({m_idx[7:0], nw[9:0], start});
        m_idx = m_idx + 1;
        if (m_ovf || m_idx == 256) m_full = 1;
    endtask

    // Returns in the cycle just after the byte was taken.
    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: in_ready stayed %0b, required 1 within 50 cycles", in_ready);
        end
        tick();
    endtask

    task automatic gap(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            in_data = 8'($urandom);
            in_last = 1'($urandom);
            tick();
        end
    endtask

    task automatic send_line(input int gap_max);
        model_line();
        for (int i = 0; i < line_q.size(); i++) begin
            send_byte(line_q[i], i == line_q.size() - 1);
            if (gap_max > 0) gap($urandom_range(0, gap_max));
        end
    endtask

    task automatic settle();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_cmp++;
        if ({which_state, in_ready, mem_we, ptr_we, overflow} !== 8'h0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %h required 00", {which_state, in_ready, mem_we, ptr_we, overflow});
        end
        n_cmp++;
        if ({mem_addr, mem_din} !== 26'd0) begin
            n_bad++;
            $display("FAIL reset_mem: got %h required 0", {mem_addr, mem_din});
        end
        n_cmp++;
        if ({ptr_idx, ptr_data, lines_written} !== 36'd0) begin
            n_bad++;
            $display("FAIL reset_ptr: got %h required 0", {ptr_idx, ptr_data, lines_written});
        end
        rst      = 1'b0;
        in_valid = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (which_state !== 4'd0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_no_enable: state %0d ready %0b, required 0 0", which_state, in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        line_q = '{8'h61, 8'h41, 8'h62, 8'h42};
        send_line(0);
        n_cmp++;
        if ({which_state, in_ready, mem_we, mem_addr, mem_din} !== {4'd3, 1'b0, 1'b1, 10'd1, 16'h6242}) begin
            n_bad++;
            $display("FAIL basic_write: state %0d rdy %0b we %0b addr %h din %h, required 3 0 1 001 6242",
                     which_state, in_ready, mem_we, mem_addr, mem_din);
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if ({which_state, in_ready, mem_we, ptr_we, ptr_idx, ptr_data} !== {4'd4, 1'b0, 1'b0, 1'b1, 8'd0, 10'd2, 10'd0}) begin
            n_bad++;
            $display("FAIL basic_commit: state %0d rdy %0b mwe %0b pwe %0b idx %0d data %h, required 4 0 0 1 0 00800",
                     which_state, in_ready, mem_we, ptr_we, ptr_idx, ptr_data);
        end
        tick();
        n_cmp++;
        if (which_state !== 4'd1 || lines_written !== 8'd1) begin
            n_bad++;
            $display("FAIL basic_after: state %0d lines %0d, required 1 1", which_state, lines_written);
        end
        line_q = '{8'h63, 8'h43};
        send_line(1);
        line_q = '{8'h78};
        send_line(2);
        settle();
        n_cmp++;
        if (mem_q.size() !== 4 || ptr_q.size() !== 3) begin
            n_bad++;
            $display("FAIL basic_counts: mem %0d ptr %0d, required 4 3", mem_q.size(), ptr_q.size());
        end else begin
            n_cmp++;
            if (mem_q[0] !== {10'd0, 16'h6141} || mem_q[1] !== {10'd1, 16'h6242} || mem_q[2] !== {10'd2, 16'h6343}) begin
                n_bad++;
                $display("FAIL basic_words: got %h %h %h, required 006141 016242 026343", mem_q[0], mem_q[1], mem_q[2]);
            end
            n_cmp++;
            if (ptr_q[1] !== {8'd1, 10'd1, 10'd2}) begin
                n_bad++;
                $display("FAIL second_line_ptr: got %h required %h", ptr_q[1], {8'd1, 10'd1, 10'd2});
            end
            n_cmp++;
            if (mem_q[3][15:0] !== 16'h7878 || ptr_q[2][19:10] !== 10'd1) begin
                n_bad++;
                $display("FAIL odd_pad: din %h len %0d, required 7878 1", mem_q[3][15:0], ptr_q[2][19:10]);
            end
        end
        n_cmp++;
        if (lines_written !== 8'd3) begin
            n_bad++;
            $display("FAIL basic_lines: got %0d required 3", lines_written);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int l = 0; l < 25; l++) begin
            line_q.delete();
            repeat ($urandom_range(1, 9)) line_q.push_back(8'($urandom));
            send_line(2);
        end
        settle();
        n_cmp++;
        if (mem_q.size() !== exp_mem.size() || ptr_q.size() !== exp_ptr.size()) begin
            n_bad++;
            $display("FAIL rand_counts: mem %0d ptr %0d, required %0d %0d", mem_q.size(), ptr_q.size(), exp_mem.size(), exp_ptr.size());
        end
        for (int i = 0; i < exp_mem.size() && i < mem_q.size(); i++) begin
            n_cmp++;
            if (mem_q[i] !== exp_mem[i] || lat_q[i] !== 1) begin
                n_bad++;
                $display("FAIL rand_mem[%0d]: got %h lat %0d, required %h lat 1", i, mem_q[i], lat_q[i], exp_mem[i]);
            end
        end
        for (int i = 0; i < exp_ptr.size() && i < ptr_q.size(); i++) begin
            n_cmp++;
            if (ptr_q[i] !== exp_ptr[i]) begin
                n_bad++;
                $display("FAIL rand_ptr[%0d]: got %h required %h", i, ptr_q[i], exp_ptr[i]);
            end
        end
        n_cmp++;
        if (lines_written !== 8'(m_idx) || both_cnt !== 0) begin
            n_bad++;
            $display("FAIL rand_lines: lines %0d both %0d, required %0d 0", lines_written, both_cnt, m_idx);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int l = 0; l < 15; l++) begin
            line_q.delete();
            repeat (2 * $urandom_range(1, 4)) line_q.push_back(8'($urandom));
            send_line(0);
        end
        in_valid = 1'b0;
        settle();
        n_cmp++;
        if (acc_cnt !== exp_bytes || acc_cnt !== 2 * mem_q.size()) begin
            n_bad++;
            $display("FAIL b2b_bytes: accepted %0d words %0d, required %0d bytes and 2x words", acc_cnt, mem_q.size(), exp_bytes);
        end
        n_cmp++;
        if (rdy_viol !== 0 || both_cnt !== 0) begin
            n_bad++;
            $display("FAIL b2b_ready: ready-in-write/commit %0d both %0d, required 0 0", rdy_viol, both_cnt);
        end
        for (int i = 0; i < exp_mem.size() && i < mem_q.size(); i++) begin
            n_cmp++;
            if (mem_q[i] !== exp_mem[i]) begin
                n_bad++;
                $display("FAIL b2b_mem[%0d]: got %h required %h", i, mem_q[i], exp_mem[i]);
            end
        end
        for (int i = 0; i < exp_ptr.size() && i < ptr_q.size(); i++) begin
            n_cmp++;
            if (ptr_q[i] !== exp_ptr[i]) begin
                n_bad++;
                $display("FAIL b2b_ptr[%0d]: got %h required %h", i, ptr_q[i], exp_ptr[i]);
            end
        end
    endtask

    task automatic test_capacity();
        int n_mem;
        do_reset();
        line_q.delete();
        repeat (2046) line_q.push_back(8'($urandom));
        send_line(0);
        settle();
        n_cmp++;
        if (mem_q.size() !== 1023 || mem_q[mem_q.size() - 1][25:16] !== 10'h3FE) begin
            n_bad++;
            $display("FAIL cap_last_write: writes %0d, required 1023 ending at 3fe", mem_q.size());
        end
        for (int i = 0; i < exp_mem.size() && i < mem_q.size(); i++) begin
            n_cmp++;
            if (mem_q[i] !== exp_mem[i]) begin
                n_bad++;
                $display("FAIL cap_mem[%0d]: got %h required %h", i, mem_q[i], exp_mem[i]);
            end
        end
        n_cmp++;
        if (ptr_q.size() !== 1 || ptr_q[0] !== {8'd0, 10'd1023, 10'd0}) begin
            n_bad++;
            $display("FAIL cap_ptr: count %0d first %h, required 1 %h", ptr_q.size(), ptr_q[0], {8'd0, 10'd1023, 10'd0});
        end
        n_cmp++;
        if (which_state !== 4'd5 || overflow !== 1'b1 || bad_addr !== 0) begin
            n_bad++;
            $display("FAIL cap_full: state %0d ovf %0b writes_3ff %0d, required 5 1 0", which_state, overflow, bad_addr);
        end
        n_mem    = mem_q.size();
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'($urandom);
            in_last = 1'($urandom);
            tick();
            n_cmp++;
            if (in_ready !== 1'b0 || which_state !== 4'd5 || mem_q.size() !== n_mem || ptr_q.size() !== 1) begin
                n_bad++;
                $display("FAIL full_terminal: rdy %0b state %0d mem %0d ptr %0d, required 0 5 %0d 1",
                         in_ready, which_state, mem_q.size(), ptr_q.size(), n_mem);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_lines_full();
        do_reset();
        for (int l = 0; l < 256; l++) begin
            line_q = '{8'($urandom)};
            send_line(0);
        end
        in_valid = 1'b0;
        settle();
        n_cmp++;
        if (which_state !== 4'd5 || overflow !== 1'b0 || lines_written !== 8'd255) begin
            n_bad++;
            $display("FAIL lines_full: state %0d ovf %0b lines %0d, required 5 0 255", which_state, overflow, lines_written);
        end
        n_cmp++;
        if (ptr_q.size() !== exp_ptr.size() || mem_q.size() !== exp_mem.size()) begin
            n_bad++;
            $display("FAIL lines_full_counts: ptr %0d mem %0d, required %0d %0d", ptr_q.size(), mem_q.size(), exp_ptr.size(), exp_mem.size());
        end
        for (int i = 0; i < exp_ptr.size() && i < ptr_q.size(); i++) begin
            n_cmp++;
            if (ptr_q[i] !== exp_ptr[i] || mem_q[i] !== exp_mem[i]) begin
                n_bad++;
                $display("FAIL lines_full[%0d]: ptr %h mem %h, required %h %h", i, ptr_q[i], mem_q[i], exp_ptr[i], exp_mem[i]);
            end
        end
    endtask

    task automatic test_reset_midline();
        int n_ptr;
        rst = 1'b1;
        tick();
        n_cmp++;
        if (which_state !== 4'd0 || lines_written !== 8'd0 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_from_full: state %0d lines %0d ovf %0b, required 0 0 0", which_state, lines_written, overflow);
        end
        do_reset();
        line_q = '{8'h61, 8'h62};
        send_line(0);
        settle();
        send_byte(8'h70, 1'b0);
        in_valid = 1'b0;
        n_ptr    = ptr_q.size();
        rst      = 1'b1;
        tick();
        n_cmp++;
        if ({which_state, in_ready, mem_we, ptr_we, overflow, mem_addr, mem_din, ptr_idx, ptr_data, lines_written} !== 70'd0) begin
            n_bad++;
            $display("FAIL midline_reset_outputs: state %0d addr %h din %h data %h lines %0d, required all 0",
                     which_state, mem_addr, mem_din, ptr_data, lines_written);
        end
        tick();
        n_cmp++;
        if (ptr_q.size() !== n_ptr) begin
            n_bad++;
            $display("FAIL midline_no_commit: ptr writes %0d, required %0d", ptr_q.size(), n_ptr);
        end
        rst = 1'b0;
        clear_all();
        line_q = '{8'h71, 8'h51};
        send_line(1);
        settle();
        n_cmp++;
        if (mem_q.size() !== 1 || mem_q[0] !== {10'd0, 16'h7151} || ptr_q.size() !== 1 || ptr_q[0] !== {8'd0, 10'd1, 10'd0}) begin
            n_bad++;
            $display("FAIL midline_restart: mem %0d/%h ptr %0d/%h, required 1/007151 1/000400",
                     mem_q.size(), mem_q[0], ptr_q.size(), ptr_q[0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_back_to_back();
        test_capacity();
        test_lines_full();
        test_reset_midline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
